column_input_ctrl: RTL
======================

Name: column_input_ctrl

Overview:
- Upstream front-end for the column-select FSM of the 4x4 Connect-4 board.
- Turns four raw, bouncing, active-low column push-buttons into one debounced, active-low one-hot column code plus a single-cycle move strobe. These feed the FSM's in_column[3:0] and enable inputs.
- Guarantees one strobe per physical press, rejects simultaneous multi-button presses, and can block presses once the game has ended.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable clock cycles required to accept a press and to accept a release. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 20: width of the debounce counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_n  input  4  raw column buttons, active-low. Bit 0 is column 0 and bit 3 is column 3. Asynchronous to clk.
- game_status  input  2  from the column-select FSM: 00 playing, 01 P1 win, 10 P2 win, 11 tie.
- out_column  output  4  debounced column code, active-low one-hot (1110 is column 0, 0111 is column 3). Held between strobes.
- out_enable  output  1  one-cycle move strobe to the FSM.
- out_state  output  2  current state, for debug.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: out_column=4'b1111, out_enable=0, out_state=IDLE (00), counter=0, both synchronizer stages=4'b1111. Reset asserted mid-press returns to IDLE immediately; a still-held button is then treated as a new press.
- Synchronizer: btn_n passes through two flops to produce sync[3:0].
- "Valid" means sync has exactly one zero bit. "Released" means sync==4'b1111.
- State encoding: IDLE=00, DEBOUNCE=01, FIRE=10, WAIT_RELEASE=11.
- IDLE:
  - If sync is valid (and not locked, see Optional Feature): capture cand<=sync, counter<=0, go to DEBOUNCE.
  - Multi-zero or released: stay in IDLE.
- DEBOUNCE:
  - If sync!=cand: go to IDLE, no strobe.
  - Else if counter==DEBOUNCE_CYCLES-1: go to FIRE.
  - Else counter<=counter+1.
- FIRE: lasts exactly one cycle.
  - out_enable=1 for this cycle only.
  - out_column<=cand, updated on the edge entering FIRE, so the column is stable during the strobe.
  - Next state is WAIT_RELEASE with counter<=0.
- WAIT_RELEASE:
  - If sync is not released: counter<=0.
  - If released and counter==DEBOUNCE_CYCLES-1: go to IDLE.
  - Otherwise counter<=counter+1.
  - A second button pressed while the first is held produces no strobe.
- Latency: a raw edge sampled at clock edge k puts the FSM in DEBOUNCE after edge k+2 and in FIRE after edge k+2+DEBOUNCE_CYCLES. out_enable is high for the cycle following that edge.
- out_column keeps its last accepted value through WAIT_RELEASE and IDLE. It changes only on entry to FIRE or on reset.
- Counter saturates by construction and never wraps; CNT_W must cover DEBOUNCE_CYCLES-1.
- Strobes are at least 2*DEBOUNCE_CYCLES+1 cycles apart.

Optional Feature:
- Macro: COLSEL_LOCKOUT_EN.
- Defined:
  - In IDLE, presses are ignored while game_status!=00.
  - A press already in DEBOUNCE is aborted to IDLE if game_status leaves 00. FIRE is never entered while game_status!=00.
  - WAIT_RELEASE behaviour is unchanged.
- Undefined: game_status is ignored, left unconnected internally and lint-waived; all presses produce strobes.

Decomposition:
- Shared package connect4_pkg:
  - State encodings IDLE/DEBOUNCE/FIRE/WAIT_RELEASE.
  - Game-status constants GS_PLAYING=2'b00, GS_P1_WIN=2'b01, GS_P2_WIN=2'b10, GS_TIE=2'b11.
  - COL_NONE=4'b1111.
- One sub-module: btn_sync2, a parameterised-width two-flop synchronizer with reset value all-ones.
- The FSM and counter stay in column_input_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, clk period 20 ns):
1. Clean press of column 1 (btn_n=1101 held 20 cycles, then 1111) -> exactly one out_enable pulse 6 cycles after the press edge, with out_column=1101; no further pulse until release plus 4 stable cycles.
2. Bounce: btn_n toggles 1110/1111 every 2 cycles for 10 cycles, then holds 1110 -> no pulse during bouncing; a single pulse with out_column=1110 six cycles after the final stable edge.
3. Multi-press: btn_n=1100 held -> no pulse and out_column unchanged. Then drop to 1101 -> one pulse with 1101.
4. Held column 0, then column 3 added (1110 then 0110) -> one pulse with 1110 only. After a full release, pressing 0111 gives a pulse with 0111.
5. Reset mid-DEBOUNCE (1011 held, reset asserted 2 cycles in) -> out_state=00, out_column=1111, out_enable=0 immediately. With 1011 still held after reset release, a pulse follows 6 cycles later.
6. COLSEL_LOCKOUT_EN defined, game_status=01, press 1110 -> no pulse. Set game_status=00 and press again -> one pulse. With the macro undefined, the same stimulus gives two pulses.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect-4 types and constants: column-input FSM states, game-status codes
// and the "no column" code.
package connect4_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        DEBOUNCE     = 2'b01,
        FIRE         = 2'b10,
        WAIT_RELEASE = 2'b11
    } col_state_e;

    localparam logic [1:0] GS_PLAYING = 2'b00;
    localparam logic [1:0] GS_P1_WIN  = 2'b01;
    localparam logic [1:0] GS_P2_WIN  = 2'b10;
    localparam logic [1:0] GS_TIE     = 2'b11;

    localparam logic [3:0] COL_NONE = 4'b1111;

    // True when exactly one active-low button is pressed.
    function automatic logic is_single_press(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

endpackage

// File: rtl/column_input_ctrl_if.sv
// Button/game-status inputs and column/strobe outputs of the column input front-end.
interface column_input_ctrl_if;
    logic [3:0] btn_n;
    logic [1:0] game_status;
    logic [3:0] out_column;
    logic       out_enable;
    logic [1:0] out_state;

    modport master (
        output btn_n,
        output game_status,
        input  out_column,
        input  out_enable,
        input  out_state
    );

    modport slave (
        input  btn_n,
        input  game_status,
        output out_column,
        output out_enable,
        output out_state
    );
endinterface

// File: rtl/btn_sync2.sv
// Parameterised-width two-flop synchronizer; resets to all-ones (buttons released).
module btn_sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/column_input_ctrl.sv
// Debounced one-hot (active-low) column code plus single-cycle move strobe.
// Define COLSEL_LOCKOUT_EN to block presses while game_status is not "playing".
module column_input_ctrl
    import connect4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input logic              clk,
    input logic              reset,
    column_input_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync;
    logic             press_ok;
    col_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       col_q, col_d;

    btn_sync2 #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (reset),
        .d_i (bus.btn_n),
        .q_o (sync)
    );

`ifdef COLSEL_LOCKOUT_EN
    assign press_ok = (bus.game_status == GS_PLAYING);
`else
    logic unused_game_status;
    assign unused_game_status = ^bus.game_status;
    assign press_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= COL_NONE;
            col_q   <= COL_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        col_d   = col_q;
        unique case (state_q)
            IDLE: begin
                if (is_single_press(sync) && press_ok) begin
                    cand_d  = sync;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // Column is latched on the edge entering FIRE so it is stable during the strobe.
                if (!press_ok || (sync != cand_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FIRE;
                    col_d   = cand_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIRE: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
            WAIT_RELEASE: begin
                if (sync != COL_NONE) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_column = col_q;
    assign bus.out_enable = (state_q == FIRE);
    assign bus.out_state  = state_q;
endmodule
